// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream reset. It re-resets the PLL on lock-wait timeout or
// on lock loss, and keeps saturating counters of both events.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [7:0] retry_count
);

  // A single counter is shared by all states, so it is sized for the largest limit.
  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_meta;
  logic          locked_s;

  // Two-flop synchronizer. pll_locked is asynchronous to refclk, and only
  // locked_s is used past this point.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // Sequencer FSM. Outputs are loaded with the value that belongs to the
  // next state, so they change on the same edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
      retry_count     <= 8'd0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a timeout that lands on the same cycle.
          if (locked_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABILIZE: begin
          // Any dropout restarts the stability window from scratch.
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
            ready   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state   <= PLL_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
          end
        end
        default: begin
          state   <= PLL_RESET;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small limits (4/8/32).
// Edge numbering in comments: E0 is the edge on which rst is still high;
// rst is released just after E0.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [7:0] retry_count;

  int n_assert = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .retry_count    (retry_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst"}, sys_rst, 1);
    chk({tag, "_ready"},   ready,   0);
    chk({tag, "_loss"},    lock_loss_count, 0);
    chk({tag, "_retry"},   retry_count, 0);
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_ready", ready, 1);
  endtask

  // Reset, release, and lock 10 cycles after release. pll_locked first
  // sampled at E11, locked_s seen by the FSM at E13 -> STABILIZE,
  // 8 counted cycles later (E21) -> RUN.
  task automatic bringup();
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst_hold");
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bu_pll_rst_hi", pll_rst, 1);
    end
    tick();                                   // E4: WAIT_LOCK
    chk("bu_pll_rst_lo", pll_rst, 0);
    chk("bu_sys_rst_wait", sys_rst, 1);
    repeat (6) tick();                        // E10
    pll_locked = 1'b1;
    repeat (10) tick();                       // E20
    chk("bu_ready_early", ready, 0);
    chk("bu_sys_rst_early", sys_rst, 1);
    tick();                                   // E21
    chk("bu_ready", ready, 1);
    chk("bu_sys_rst_rel", sys_rst, 0);
    chk("bu_pll_rst_run", pll_rst, 0);
    chk("bu_loss", lock_loss_count, 0);
    chk("bu_retry", retry_count, 0);
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;

    // Normal bring-up, ends in RUN at E21
    bringup();

    // Lock loss in RUN: drop after E21, locked_s low seen at E24
    pll_locked = 1'b0;
    tick(); tick();                           // E23
    chk("ll_ready_still", ready, 1);
    tick();                                   // E24
    chk("ll_ready", ready, 0);
    chk("ll_sys_rst", sys_rst, 1);
    chk("ll_pll_rst", pll_rst, 1);
    chk("ll_count", lock_loss_count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ll_pll_rst_hold", pll_rst, 1);
    end
    tick();                                   // E28: WAIT_LOCK
    chk("ll_pll_rst_end", pll_rst, 0);

    // Unstable lock: high 5, low 1, then high. STABILIZE at E31, drop seen
    // at E36 -> WAIT_LOCK, back to STABILIZE at E37, RUN at E45.
    pll_locked = 1'b1;
    repeat (5) tick();                        // E33
    pll_locked = 1'b0;
    tick();                                   // E34
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin        // E35..E44
      tick();
      chk("ul_no_pll_rst", pll_rst, 0);
      chk("ul_not_ready", ready, 0);
    end
    tick();                                   // E45
    chk("ul_ready", ready, 1);
    chk("ul_retry", retry_count, 0);
    chk("ul_loss", lock_loss_count, 1);

    // Repeated lock loss up to saturation
    for (int i = 2; i <= 256; i++) begin
      pll_locked = 1'b0;
      tick(); tick();
      chk("lls_ready_still", ready, 1);
      tick();
      chk("lls_ready_drop", ready, 0);
      chk("lls_count", lock_loss_count, (i > 255) ? 255 : i);
      pll_locked = 1'b1;
      wait_ready(40);
    end

    // Reset during STABILIZE with lock_loss_count saturated
    pll_locked = 1'b0;
    repeat (3) tick();                        // Ed3: PLL_RESET
    chk("st_loss_sat", lock_loss_count, 255);
    pll_locked = 1'b1;
    repeat (6) tick();                        // Ed9: STABILIZE, cnt=1
    chk("st_pll_rst", pll_rst, 0);
    chk("st_sys_rst", sys_rst, 1);
    chk("st_ready", ready, 0);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_stab");
    bringup();

    // Reset during RUN with a nonzero lock_loss_count
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_ready(40);
    chk("run_loss_one", lock_loss_count, 1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_run");
    bringup();

    // Timeout: lock never arrives. WAIT_LOCK from E4, counter hits 31 at E35,
    // timeout at E36, period 36. A sub-period glitch at E4 is ignored.
    pll_locked = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();                        // E4
    chk("to_wait", pll_rst, 0);
    #1 pll_locked = 1'b1;
    #2 pll_locked = 1'b0;
    repeat (31) tick();                       // E35
    chk("to_pll_rst_pre", pll_rst, 0);
    chk("to_retry_pre", retry_count, 0);
    chk("to_glitch_ready", ready, 0);
    tick();                                   // E36
    chk("to_pll_rst", pll_rst, 1);
    chk("to_retry1", retry_count, 1);
    repeat (3) tick();                        // E39
    chk("to_pll_rst_hold", pll_rst, 1);
    tick();                                   // E40
    chk("to_pll_rst_end", pll_rst, 0);
    repeat (31) tick();                       // E71
    chk("to_low_32", pll_rst, 0);
    tick();                                   // E72
    chk("to_retry2", retry_count, 2);
    chk("to_pll_rst2", pll_rst, 1);
    for (int i = 3; i <= 257; i++) begin
      repeat (36) tick();
      chk("to_retry_sat", retry_count, (i > 255) ? 255 : i);
      chk("to_pulse", pll_rst, 1);
    end

    // Lock and timeout on the same cycle: locked_s is high during the cycle
    // with counter 31 (E35), so E36 goes to STABILIZE, RUN at E44.
    pll_locked = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("sim_retry_cleared", retry_count, 0);
    rst = 1'b0;
    repeat (33) tick();                       // E33
    pll_locked = 1'b1;
    repeat (3) tick();                        // E36
    chk("sim_no_pll_rst", pll_rst, 0);
    chk("sim_retry", retry_count, 0);
    repeat (7) tick();                        // E43
    chk("sim_ready_early", ready, 0);
    tick();                                   // E44
    chk("sim_ready", ready, 1);
    chk("sim_retry_end", retry_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case the directed sequence stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
